// File: rtl/grid_move_sequencer.sv
// Command-queued grid walker: buffers (dir, steps) moves in a FIFO and executes
// them one unit step per clock, clamping at the grid edges.
//
// state | meaning
// IDLE  | waiting; pops the FIFO head when non-empty
// STEP  | applying one unit move per edge until rem runs out
module grid_move_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_dir,
    input  logic [1:0]               cmd_steps,
    output logic [W-1:0]             pos_x,
    output logic [W-1:0]             pos_y,
    output logic                     busy,
    output logic                     done,
    output logic                     bump,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);
    localparam logic [W-1:0] MAX  = '1;

    typedef enum logic {IDLE, STEP} state_t;

    state_t          state;
    logic [1:0]      dir_mem   [DEPTH];
    logic [1:0]      steps_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      cur_dir;
    logic [1:0]      rem;
    logic            push;
    logic            pop;
    logic            at_edge;

    assign cmd_ready = (count < FULL) && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state == STEP) || (count != '0);

    always_comb begin
        at_edge = 1'b0;
        case (cur_dir)
            2'd0: at_edge = (pos_x == MAX);
            2'd1: at_edge = (pos_x == '0);
            2'd2: at_edge = (pos_y == MAX);
            2'd3: at_edge = (pos_y == '0);
            default: at_edge = 1'b0;
        endcase
    end

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            dir_mem[wr_ptr]   <= cmd_dir;
            steps_mem[wr_ptr] <= cmd_steps;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cur_dir <= 2'd0;
            rem     <= 2'd0;
            pos_x   <= '0;
            pos_y   <= '0;
            done    <= 1'b0;
            bump    <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            done <= 1'b0;
            bump <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_dir <= dir_mem[rd_ptr];
                        rem     <= steps_mem[rd_ptr];
                        if (steps_mem[rd_ptr] == 2'd0) done <= 1'b1;
                        else                           state <= STEP;
                    end
                end
                STEP: begin
                    // A clamped step still consumes one unit of rem.
                    if (at_edge) begin
                        bump <= 1'b1;
                    end else begin
                        case (cur_dir)
                            2'd0: pos_x <= pos_x + 1'b1;
                            2'd1: pos_x <= pos_x - 1'b1;
                            2'd2: pos_y <= pos_y + 1'b1;
                            default: pos_y <= pos_y - 1'b1;
                        endcase
                    end
                    rem <= rem - 1'b1;
                    if (rem == 2'd1) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grid_move_sequencer.sv
// Directed bench for grid_move_sequencer: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_grid_move_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    logic [1:0] cmd_steps;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       busy;
    logic       done;
    logic       bump;
    logic [2:0] count;

    int passed = 0;
    int total  = 0;
    int done_tot = 0;
    int bump_tot = 0;
    int d0, b0, accepted, max_cnt;

    grid_move_sequencer #(.DEPTH(4), .W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy), .done(done), .bump(bump), .count(count)
    );

    always #5 clk = ~clk;

    // Pulses are one cycle wide, so counting high cycles counts pulses.
    always @(negedge clk) begin
        if (done) done_tot++;
        if (bump) bump_tot++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic [1:0] d, input logic [1:0] s);
        int waited;
        waited = 0;
        cmd_dir = d;
        cmd_steps = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) check("push_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("idle_timeout", 0, 1);
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir = 2'd0;
        cmd_steps = 2'd0;

        // Reset state
        repeat (2) tick();
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_pos_x", int'(pos_x), 0);
        check("rst_pos_y", int'(pos_y), 0);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        tick();
        check("ready_after_rst", int'(cmd_ready), 1);

        // Single move: (+x, 3)
        d0 = done_tot; b0 = bump_tot;
        cmd_dir = 2'd0; cmd_steps = 2'd3; cmd_valid = 1'b1;
        tick();                                  // edge k
        cmd_valid = 1'b0;
        check("sm_count_k", int'(count), 1);
        check("sm_busy_k", int'(busy), 1);
        tick();                                  // edge k+1 (pop)
        check("sm_count_k1", int'(count), 0);
        check("sm_x_k1", int'(pos_x), 0);
        tick();
        check("sm_x_k2", int'(pos_x), 1);
        check("sm_done_k2", int'(done), 0);
        tick();
        check("sm_x_k3", int'(pos_x), 2);
        tick();
        check("sm_x_k4", int'(pos_x), 3);
        check("sm_done_k4", int'(done), 1);
        tick();
        check("sm_done_k5", int'(done), 0);
        check("sm_busy_k5", int'(busy), 0);
        tick();
        check("sm_done_cnt", done_tot - d0, 1);
        check("sm_bump_cnt", bump_tot - b0, 0);
        check("sm_pos_y", int'(pos_y), 0);

        // Clamp at the lower edges
        do_reset();
        d0 = done_tot; b0 = bump_tot;
        push(2'd1, 2'd2);
        push(2'd3, 2'd1);
        wait_idle();
        check("cl_pos_x", int'(pos_x), 0);
        check("cl_pos_y", int'(pos_y), 0);
        check("cl_bump_cnt", bump_tot - b0, 3);
        check("cl_done_cnt", done_tot - d0, 2);

        // Upper edge: 18 +x steps from 0
        do_reset();
        b0 = bump_tot;
        for (int i = 0; i < 6; i++) push(2'd0, 2'd3);
        wait_idle();
        check("up_pos_x", int'(pos_x), 15);
        check("up_pos_y", int'(pos_y), 0);
        check("up_bump_cnt", bump_tot - b0, 3);

        // Back-pressure: valid held 20 cycles with (+y, 3)
        do_reset();
        d0 = done_tot; b0 = bump_tot;
        accepted = 0; max_cnt = 0;
        cmd_dir = 2'd2; cmd_steps = 2'd3; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (count == 3'd4) check("bp_ready_full", int'(cmd_ready), 0);
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        check("bp_max_count", max_cnt, 4);
        check("bp_accepted", accepted, 9);
        wait_idle();
        check("bp_done_cnt", done_tot - d0, accepted);
        check("bp_pos_y", int'(pos_y), 15);
        check("bp_bump_cnt", bump_tot - b0, 12);

        // Mixed sequence with a zero-step command
        do_reset();
        d0 = done_tot;
        push(2'd0, 2'd3);
        push(2'd2, 2'd2);
        push(2'd3, 2'd1);
        push(2'd1, 2'd1);
        push(2'd2, 2'd0);
        wait_idle();
        check("mx_pos_x", int'(pos_x), 2);
        check("mx_pos_y", int'(pos_y), 1);
        check("mx_done_cnt", done_tot - d0, 5);

        // Reset mid-move with two commands queued
        do_reset();
        push(2'd0, 2'd3);
        push(2'd0, 2'd3);
        push(2'd0, 2'd3);
        check("rm_count_pre", int'(count), 2);
        check("rm_x_pre", int'(pos_x), 1);
        d0 = done_tot;
        reset = 1'b1;
        #1;
        check("rm_ready_in_rst", int'(cmd_ready), 0);
        tick();
        reset = 1'b0;
        check("rm_pos_x", int'(pos_x), 0);
        check("rm_pos_y", int'(pos_y), 0);
        check("rm_count", int'(count), 0);
        check("rm_busy", int'(busy), 0);
        check("rm_done", int'(done), 0);
        repeat (8) tick();
        check("rm_x_after", int'(pos_x), 0);
        check("rm_done_cnt", done_tot - d0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
